// File: rtl/sprite_draw_scheduler.sv
// Walks the enabled sprite slots once per frame and hands each one to the
// single drawing engine over a draw/ready handshake, with a per-phase watchdog.
module sprite_draw_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int TIMEOUT_CYCLES = 2000000,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          slotWrite,
  input  logic [SW-1:0] slotIndex,
  input  logic [8:0]    slotX,
  input  logic [9:0]    slotY,
  input  logic [3:0]    slotROMId,
  input  logic          slotEnable,
  input  logic          frameStart,
  input  logic          drawReady,
  output logic          draw,
  output logic [8:0]    drawX,
  output logic [9:0]    drawY,
  output logic [3:0]    drawROMId,
  output logic          frameBusy,
  output logic          frameDone,
  output logic [4:0]    slotsDrawn,
  output logic          timeoutError
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW:0]    IDX_END = (SW + 1)'(NUM_SLOTS);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT_ACCEPT, WAIT_DONE, DONE} state_t;

  typedef struct packed {
    logic [8:0] x;
    logic [9:0] y;
    logic [3:0] rom;
    logic       en;
  } slot_t;

  slot_t          slot_reg [NUM_SLOTS];
  slot_t          cur_slot;
  state_t         state_reg, state_next;
  logic [SW:0]    idx_reg;
  logic [WDW-1:0] wd_reg;
  logic [8:0]     draw_x_reg;
  logic [9:0]     draw_y_reg;
  logic [3:0]     draw_rom_reg;
  logic [4:0]     slots_drawn_reg;
  logic           timeout_error_reg;
  logic           at_end, waiting, wd_expired, abandon;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_reg[i] <= '0;
    end else if (slotWrite) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        if (int'(slotIndex) == i) slot_reg[i] <= {slotX, slotY, slotROMId, slotEnable};
    end
  end

  // idx_reg reaches NUM_SLOTS at the end of a pass, so the table read is guarded
  always_comb begin
    cur_slot = '0;
    if (idx_reg < IDX_END) cur_slot = slot_reg[idx_reg[SW-1:0]];
  end

  assign at_end     = (idx_reg == IDX_END);
  assign waiting    = (state_reg == ISSUE) || (state_reg == WAIT_ACCEPT) || (state_reg == WAIT_DONE);
  assign wd_expired = waiting && (wd_reg == WD_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // A completed handshake phase wins over a watchdog expiry in the same cycle
  always_comb begin
    state_next = state_reg;
    abandon    = 1'b0;
    case (state_reg)
      IDLE:        if (frameStart) state_next = SCAN;
      SCAN: begin
        if (at_end)           state_next = DONE;
        else if (cur_slot.en) state_next = ISSUE;
      end
      ISSUE:       if (drawReady)  state_next = WAIT_ACCEPT;
                   else if (wd_expired) begin state_next = SCAN; abandon = 1'b1; end
      WAIT_ACCEPT: if (!drawReady) state_next = WAIT_DONE;
                   else if (wd_expired) begin state_next = SCAN; abandon = 1'b1; end
      WAIT_DONE:   if (drawReady)  state_next = SCAN;
                   else if (wd_expired) begin state_next = SCAN; abandon = 1'b1; end
      DONE:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx_reg           <= '0;
      wd_reg            <= '0;
      draw_x_reg        <= '0;
      draw_y_reg        <= '0;
      draw_rom_reg      <= '0;
      slots_drawn_reg   <= '0;
      timeout_error_reg <= 1'b0;
    end else begin
      if (state_next != state_reg) wd_reg <= '0;
      else if (waiting)            wd_reg <= wd_reg + 1'b1;
      case (state_reg)
        IDLE: if (frameStart) begin
          idx_reg         <= '0;
          slots_drawn_reg <= '0;
        end
        SCAN: if (!at_end) begin
          if (cur_slot.en) begin
            draw_x_reg   <= cur_slot.x;
            draw_y_reg   <= cur_slot.y;
            draw_rom_reg <= cur_slot.rom;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        WAIT_DONE: if (drawReady) begin
          slots_drawn_reg <= slots_drawn_reg + 1'b1;
          idx_reg         <= idx_reg + 1'b1;
        end
        default: ;
      endcase
      if (abandon) begin
        timeout_error_reg <= 1'b1;
        idx_reg           <= idx_reg + 1'b1;
      end
    end
  end

  always_comb begin
    draw      = (state_reg == WAIT_ACCEPT);
    frameBusy = (state_reg != IDLE);
    frameDone = (state_reg == DONE);
  end

  assign drawX        = draw_x_reg;
  assign drawY        = draw_y_reg;
  assign drawROMId    = draw_rom_reg;
  assign slotsDrawn   = slots_drawn_reg;
  assign timeoutError = timeout_error_reg;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Randomized bench for sprite_draw_scheduler: a behavioural engine model plus a
// slot-table model predict the ordered draw list and pass results per frame.
module tb_sprite_draw_scheduler;
  localparam int N   = 4;
  localparam int TMO = 100;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       slotWrite = 1'b0;
  logic [1:0] slotIndex = '0;
  logic [8:0] slotX = '0;
  logic [9:0] slotY = '0;
  logic [3:0] slotROMId = '0;
  logic       slotEnable = 1'b0;
  logic       frameStart = 1'b0;
  logic       drawReady;
  logic       draw;
  logic [8:0] drawX;
  logic [9:0] drawY;
  logic [3:0] drawROMId;
  logic       frameBusy, frameDone, timeoutError;
  logic [4:0] slotsDrawn;

  sprite_draw_scheduler #(.NUM_SLOTS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .slotWrite(slotWrite), .slotIndex(slotIndex),
    .slotX(slotX), .slotY(slotY), .slotROMId(slotROMId), .slotEnable(slotEnable),
    .frameStart(frameStart), .drawReady(drawReady), .draw(draw), .drawX(drawX),
    .drawY(drawY), .drawROMId(drawROMId), .frameBusy(frameBusy), .frameDone(frameDone),
    .slotsDrawn(slotsDrawn), .timeoutError(timeoutError)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  // slot table model (m_*) and a snapshot taken at pass start (s_*)
  logic [8:0] m_x [N], s_x [N];
  logic [9:0] m_y [N], s_y [N];
  logic [3:0] m_rom [N], s_rom [N];
  logic       m_en [N], s_en [N];
  logic [22:0] eng_log [$];
  logic [22:0] exp_q [$];

  int   eng_phase = 0, eng_cnt = 0, eng_drop = 3, eng_busy = 50;
  bit   eng_stuck = 0;
  int   draw_rises = 0;
  logic draw_prev = 1'b0;

  // engine: accepts a draw, drops ready eng_drop cycles later, restores eng_busy later
  initial begin
    drawReady = 1'b1;
    forever begin
      @(negedge clock);
      if (draw === 1'b1 && draw_prev !== 1'b1) draw_rises++;
      draw_prev = draw;
      if (!reset_n) begin
        eng_phase = 0;
        drawReady = !eng_stuck;
      end else if (eng_stuck) begin
        eng_phase = 0;
        drawReady = 1'b0;
      end else begin
        case (eng_phase)
          0: begin
            drawReady = 1'b1;
            if (draw === 1'b1) begin
              eng_log.push_back({drawX, drawY, drawROMId});
              eng_cnt = eng_drop;
              eng_phase = 1;
            end
          end
          1: begin
            eng_cnt--;
            if (eng_cnt <= 0) begin drawReady = 1'b0; eng_cnt = eng_busy; eng_phase = 2; end
          end
          default: begin
            eng_cnt--;
            if (eng_cnt <= 0) begin drawReady = 1'b1; eng_phase = 0; end
          end
        endcase
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; frameStart = 1'b0; slotWrite = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin m_x[i] = '0; m_y[i] = '0; m_rom[i] = '0; m_en[i] = 1'b0; end
  endtask

  task automatic write_slot(input int idx, input logic [8:0] x, input logic [9:0] y,
                            input logic [3:0] rom, input logic en);
    @(negedge clock);
    slotWrite = 1'b1; slotIndex = 2'(idx); slotX = x; slotY = y; slotROMId = rom; slotEnable = en;
    @(negedge clock);
    slotWrite = 1'b0;
    m_x[idx] = x; m_y[idx] = y; m_rom[idx] = rom; m_en[idx] = en;
  endtask

  task automatic take_snapshot();
    for (int i = 0; i < N; i++) begin s_x[i] = m_x[i]; s_y[i] = m_y[i]; s_rom[i] = m_rom[i]; s_en[i] = m_en[i]; end
  endtask

  // slots up to 'split' are drawn as they were at pass start, later ones as now
  task automatic build_expected(input int split);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (i <= split) begin
        if (s_en[i]) exp_q.push_back({s_x[i], s_y[i], s_rom[i]});
      end else begin
        if (m_en[i]) exp_q.push_back({m_x[i], m_y[i], m_rom[i]});
      end
    end
  endtask

  // cycle 1 is the first cycle after the edge that samples frameStart
  task automatic run_pass(input int extra_at, output int done_cycle, output int done_count,
                          output int busy_gaps, output int err_cycle);
    int cyc;
    done_cycle = -1; done_count = 0; busy_gaps = 0; err_cycle = -1;
    @(negedge clock); frameStart = 1'b1;
    @(negedge clock); frameStart = 1'b0;
    cyc = 1;
    while (cyc < 5000) begin
      if (frameDone === 1'b1) begin done_count++; if (done_cycle < 0) done_cycle = cyc; end
      if (done_cycle < 0 && frameBusy !== 1'b1) busy_gaps++;
      if (err_cycle < 0 && timeoutError === 1'b1) err_cycle = cyc;
      if (done_cycle >= 0 && cyc >= done_cycle + 8) break;
      frameStart = (cyc == extra_at && frameBusy === 1'b1 && done_cycle < 0);
      @(negedge clock);
      cyc++;
    end
    frameStart = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (draw !== 1'b0) begin n_fails++; $display("FAIL reset_draw: got %b expected 0", draw); end
    n_checks++; if (frameBusy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", frameBusy); end
    n_checks++; if (frameDone !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b expected 0", frameDone); end
    n_checks++; if (timeoutError !== 1'b0) begin n_fails++; $display("FAIL reset_timeout: got %b expected 0", timeoutError); end
    n_checks++; if ({drawX, drawY, drawROMId} !== 23'd0) begin n_fails++; $display("FAIL reset_fields: got %h expected 0", {drawX, drawY, drawROMId}); end
    n_checks++; if (slotsDrawn !== 5'd0) begin n_fails++; $display("FAIL reset_slots: got %0d expected 0", slotsDrawn); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_basic();
    int dc, dn, gaps, ec;
    do_reset();
    eng_stuck = 0; eng_drop = 3; eng_busy = 50;
    write_slot(0, 9'd120, 10'd160, 4'd2, 1'b1);
    write_slot(2, 9'd10, 10'd300, 4'd5, 1'b1);
    take_snapshot(); build_expected(N - 1);
    eng_log.delete(); draw_rises = 0;
    run_pass(0, dc, dn, gaps, ec);
    n_checks++; if (dc < 0) begin n_fails++; $display("FAIL basic_complete: got no frameDone expected one within budget"); end
    n_checks++; if (dn != 1) begin n_fails++; $display("FAIL basic_done_count: got %0d expected 1", dn); end
    n_checks++; if (gaps != 0) begin n_fails++; $display("FAIL basic_busy: got %0d idle cycles expected 0", gaps); end
    n_checks++; if (draw_rises != exp_q.size()) begin n_fails++; $display("FAIL basic_pulses: got %0d expected %0d", draw_rises, exp_q.size()); end
    n_checks++; if (eng_log.size() != exp_q.size()) begin n_fails++; $display("FAIL basic_draws: got %0d expected %0d", eng_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < eng_log.size(); i++) begin
      n_checks++; if (eng_log[i] !== exp_q[i]) begin n_fails++; $display("FAIL basic_draw%0d: got %h expected %h", i, eng_log[i], exp_q[i]); end
    end
    n_checks++; if (slotsDrawn !== 5'(exp_q.size())) begin n_fails++; $display("FAIL basic_slots: got %0d expected %0d", slotsDrawn, exp_q.size()); end
    $display("test_basic: %0d draws, done at cycle %0d, slotsDrawn %0d", eng_log.size(), dc, slotsDrawn);
  endtask

  task automatic test_all_disabled();
    int dc, dn, gaps, ec;
    do_reset();
    eng_log.delete(); draw_rises = 0;
    run_pass(0, dc, dn, gaps, ec);
    n_checks++; if (dc != N + 2) begin n_fails++; $display("FAIL empty_latency: got %0d expected %0d", dc, N + 2); end
    n_checks++; if (dn != 1) begin n_fails++; $display("FAIL empty_done_count: got %0d expected 1", dn); end
    n_checks++; if (draw_rises != 0) begin n_fails++; $display("FAIL empty_pulses: got %0d expected 0", draw_rises); end
    n_checks++; if (slotsDrawn !== 5'd0) begin n_fails++; $display("FAIL empty_slots: got %0d expected 0", slotsDrawn); end
    $display("test_all_disabled: done at cycle %0d", dc);
  endtask

  task automatic test_timeout();
    int dc, dn, gaps, ec;
    do_reset();
    write_slot(1, 9'($urandom_range(0, 511)), 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), 1'b1);
    eng_stuck = 1;
    eng_log.delete(); draw_rises = 0;
    run_pass(0, dc, dn, gaps, ec);
    // two SCAN cycles (slot0 skipped, slot1 latched), TMO cycles in ISSUE, flag visible next cycle
    n_checks++; if (ec != 2 + TMO + 1) begin n_fails++; $display("FAIL timeout_cycle: got %0d expected %0d", ec, 2 + TMO + 1); end
    n_checks++; if (dc < 0 || dn != 1) begin n_fails++; $display("FAIL timeout_pass: got done %0d count %0d expected one frameDone", dc, dn); end
    n_checks++; if (draw_rises != 0) begin n_fails++; $display("FAIL timeout_draw: got %0d pulses expected 0", draw_rises); end
    n_checks++; if (slotsDrawn !== 5'd0) begin n_fails++; $display("FAIL timeout_slots: got %0d expected 0", slotsDrawn); end
    eng_stuck = 0;
    @(negedge clock);
    take_snapshot(); build_expected(N - 1);
    eng_log.delete(); draw_rises = 0;
    run_pass(0, dc, dn, gaps, ec);
    n_checks++; if (timeoutError !== 1'b1) begin n_fails++; $display("FAIL timeout_sticky: got %b expected 1", timeoutError); end
    n_checks++; if (slotsDrawn !== 5'(exp_q.size())) begin n_fails++; $display("FAIL timeout_recover: got %0d expected %0d", slotsDrawn, exp_q.size()); end
    n_checks++; if (eng_log.size() != 1 || eng_log[0] !== exp_q[0]) begin n_fails++; $display("FAIL timeout_redraw: got %0d draws expected 1 of %h", eng_log.size(), exp_q[0]); end
    $display("test_timeout: error at cycle %0d, sticky %b", ec, timeoutError);
  endtask

  task automatic test_midpass_write();
    int dc, dn, gaps, ec, w;
    do_reset();
    eng_stuck = 0; eng_drop = 3; eng_busy = 50;
    write_slot(0, 9'd120, 10'd160, 4'd2, 1'b1);
    take_snapshot();
    eng_log.delete(); draw_rises = 0;
    fork
      run_pass(0, dc, dn, gaps, ec);
      begin
        w = 0;
        while (eng_log.size() == 0 && w < 200) begin @(negedge clock); w++; end
        n_checks++; if (eng_log.size() == 0) begin n_fails++; $display("FAIL midpass_wait: got no draw within %0d cycles", w); end
        write_slot(3, 9'd50, 10'd60, 4'd1, 1'b1);
        write_slot(0, 9'd0, 10'd0, 4'd2, 1'b1);
        n_checks++; if (drawX !== 9'd120 || drawY !== 10'd160) begin n_fails++; $display("FAIL midpass_inflight: got (%0d,%0d) expected (120,160)", drawX, drawY); end
      end
    join
    build_expected(0);
    n_checks++; if (eng_log.size() != exp_q.size()) begin n_fails++; $display("FAIL midpass_draws: got %0d expected %0d", eng_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < eng_log.size(); i++) begin
      n_checks++; if (eng_log[i] !== exp_q[i]) begin n_fails++; $display("FAIL midpass_draw%0d: got %h expected %h", i, eng_log[i], exp_q[i]); end
    end
    take_snapshot(); build_expected(N - 1);
    eng_log.delete();
    run_pass(0, dc, dn, gaps, ec);
    n_checks++; if (eng_log.size() != exp_q.size()) begin n_fails++; $display("FAIL nextpass_draws: got %0d expected %0d", eng_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < eng_log.size(); i++) begin
      n_checks++; if (eng_log[i] !== exp_q[i]) begin n_fails++; $display("FAIL nextpass_draw%0d: got %h expected %h", i, eng_log[i], exp_q[i]); end
    end
    $display("test_midpass_write: next pass drew %0d slots", eng_log.size());
  endtask

  // random tables and engine timing, with a stray frameStart while busy each pass
  task automatic test_back_to_back(input int passes, input string tag);
    int dc, dn, gaps, ec;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) != 0)
          write_slot(i, 9'($urandom_range(0, 511)), 10'($urandom_range(0, 1023)),
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      eng_drop = $urandom_range(1, 5);
      eng_busy = $urandom_range(1, 60);
      take_snapshot(); build_expected(N - 1);
      eng_log.delete(); draw_rises = 0;
      run_pass($urandom_range(2, 10), dc, dn, gaps, ec);
      n_checks++; if (dn != 1) begin n_fails++; $display("FAIL %s%0d_done_count: got %0d expected 1", tag, p, dn); end
      n_checks++; if (gaps != 0) begin n_fails++; $display("FAIL %s%0d_busy: got %0d idle cycles expected 0", tag, p, gaps); end
      n_checks++; if (eng_log.size() != exp_q.size()) begin n_fails++; $display("FAIL %s%0d_draws: got %0d expected %0d", tag, p, eng_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < eng_log.size(); i++) begin
        n_checks++; if (eng_log[i] !== exp_q[i]) begin n_fails++; $display("FAIL %s%0d_draw%0d: got %h expected %h", tag, p, i, eng_log[i], exp_q[i]); end
      end
      n_checks++; if (slotsDrawn !== 5'(exp_q.size())) begin n_fails++; $display("FAIL %s%0d_slots: got %0d expected %0d", tag, p, slotsDrawn, exp_q.size()); end
      $display("%s pass %0d: %0d draws, slotsDrawn %0d, done at cycle %0d", tag, p, eng_log.size(), slotsDrawn, dc);
    end
  endtask

  task automatic test_reset_midpass();
    int dc, dn, gaps, ec, w;
    do_reset();
    eng_stuck = 0; eng_drop = 3; eng_busy = 20;
    for (int i = 0; i < N; i++) write_slot(i, 9'(i + 1), 10'(i + 7), 4'(i), 1'b1);
    @(negedge clock); frameStart = 1'b1;
    @(negedge clock); frameStart = 1'b0;
    w = 0;
    while (draw !== 1'b1 && w < 20) begin @(negedge clock); w++; end
    n_checks++; if (draw !== 1'b1) begin n_fails++; $display("FAIL rstmid_draw_seen: got %b expected 1", draw); end
    reset_n = 1'b0;
    @(negedge clock);
    n_checks++; if (draw !== 1'b0) begin n_fails++; $display("FAIL rstmid_draw: got %b expected 0", draw); end
    n_checks++; if (frameBusy !== 1'b0) begin n_fails++; $display("FAIL rstmid_busy: got %b expected 0", frameBusy); end
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin m_x[i] = '0; m_y[i] = '0; m_rom[i] = '0; m_en[i] = 1'b0; end
    @(negedge clock);
    eng_log.delete(); draw_rises = 0;
    run_pass(0, dc, dn, gaps, ec);
    n_checks++; if (draw_rises != 0) begin n_fails++; $display("FAIL rstmid_table: got %0d draws expected 0", draw_rises); end
    n_checks++; if (dc != N + 2) begin n_fails++; $display("FAIL rstmid_latency: got %0d expected %0d", dc, N + 2); end
    $display("test_reset_midpass: pass after reset done at cycle %0d", dc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_disabled();
    test_timeout();
    test_midpass_write();
    test_back_to_back(4, "b2b");
    test_back_to_back(8, "rand");
    test_reset_midpass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
